// File: rtl/axi_slave_port_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port between NB_REQ requesters.
// One transaction in flight; requests outside [START_ADDR, END_ADDR] get a local error response.
module axi_slave_port_arbiter #(
  parameter int                    NB_REQ     = 3,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h1A10_0000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h1A11_FFFF,
  localparam int                   IDW        = $clog2(NB_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_REQ-1:0]            req_valid_i,
  output logic [NB_REQ-1:0]            req_ready_o,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NB_REQ-1:0]            req_we_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NB_REQ-1:0]            rsp_valid_o,
  input  logic [NB_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]        rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         slv_valid_o,
  input  logic                         slv_ready_i,
  output logic [ADDR_WIDTH-1:0]        slv_addr_o,
  output logic                         slv_we_o,
  output logic [DATA_WIDTH-1:0]        slv_wdata_o,
  input  logic                         slv_rsp_valid_i,
  output logic                         slv_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]        slv_rsp_rdata_i,
  input  logic                         slv_rsp_err_i,
  output logic [IDW-1:0]               gnt_id_o,
  output logic                         busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DEC_ERR  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [IDW-1:0]          ptr_r, gnt_id_r, winner_s;
  logic [ADDR_WIDTH-1:0]   addr_r, win_addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, win_wdata_s, rdata_r;
  logic                    we_r, win_we_s, err_r;
  logic                    found_s, in_window_s, rsp_hs_s;
  int                      best_dist_s, dist_s;

  // Winner is the valid requester closest above the pointer, wrapping around.
  always_comb begin
    found_s     = 1'b0;
    winner_s    = '0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_we_s    = 1'b0;
    best_dist_s = NB_REQ;
    dist_s      = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      dist_s = (i + 2 * NB_REQ - int'(ptr_r) - 1) % NB_REQ;
      if (req_valid_i[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        found_s     = 1'b1;
        winner_s    = IDW'(i);
        win_addr_s  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata_s = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        win_we_s    = req_we_i[i];
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    in_window_s = (win_addr_s >= START_ADDR) && (win_addr_s <= END_ADDR);
  end

  // Per-requester handshake decode; ready is gated by rst_n so it drops with reset.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_hs_s    = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      req_ready_o[i] = rst_n && (state_r == ST_IDLE) && found_s && (winner_s == IDW'(i));
      if ((state_r == ST_RESP) && (gnt_id_r == IDW'(i))) begin
        rsp_valid_o[i] = 1'b1;
        rsp_hs_s       = rsp_ready_i[i];
      end else begin
        rsp_valid_o[i] = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nx_s = in_window_s ? ST_ISSUE : ST_DEC_ERR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (slv_ready_i) state_nx_s = ST_WAIT_RSP;
        else             state_nx_s = ST_ISSUE;
      end
      ST_WAIT_RSP: begin
        if (slv_rsp_valid_i) state_nx_s = ST_RESP;
        else                 state_nx_s = ST_WAIT_RSP;
      end
      ST_DEC_ERR: state_nx_s = ST_RESP;
      ST_RESP: begin
        if (rsp_hs_s) state_nx_s = ST_IDLE;
        else          state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Transaction fields, response capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= IDW'(NB_REQ - 1);
      gnt_id_r <= '0;
      addr_r   <= '0;
      we_r     <= 1'b0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            gnt_id_r <= winner_s;
            addr_r   <= win_addr_s;
            we_r     <= win_we_s;
            wdata_r  <= win_wdata_s;
          end
        end
        ST_WAIT_RSP: begin
          if (slv_rsp_valid_i) begin
            rdata_r <= slv_rsp_rdata_i;
            err_r   <= slv_rsp_err_i;
          end
        end
        ST_DEC_ERR: begin
          rdata_r <= '0;
          err_r   <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_hs_s) ptr_r <= gnt_id_r;
        end
        default: ptr_r <= ptr_r;
      endcase
    end
  end

  assign slv_valid_o     = (state_r == ST_ISSUE);
  assign slv_rsp_ready_o = (state_r == ST_WAIT_RSP);
  assign slv_addr_o      = addr_r;
  assign slv_we_o        = we_r;
  assign slv_wdata_o     = wdata_r;
  assign rsp_rdata_o     = rdata_r;
  assign rsp_err_o       = err_r;
  assign gnt_id_o        = gnt_id_r;
  assign busy_o          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_axi_slave_port_arbiter.sv
// Directed bench for axi_slave_port_arbiter: single read, decode error, round robin,
// stalls, slave error and asynchronous reset mid-transaction.
module tb_axi_slave_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
  logic [95:0] req_addr_i, req_wdata_i;
  logic [31:0] rsp_rdata_o, slv_addr_o, slv_wdata_o, slv_rsp_rdata_i;
  logic        rsp_err_o, slv_valid_o, slv_ready_i, slv_we_o;
  logic        slv_rsp_valid_i, slv_rsp_ready_o, slv_rsp_err_i, busy_o;
  logic [1:0]  gnt_id_o;
  int          n_tests;
  int          n_fail;

  axi_slave_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .slv_valid_o(slv_valid_o), .slv_ready_i(slv_ready_i), .slv_addr_o(slv_addr_o),
    .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o),
    .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
    .slv_rsp_rdata_i(slv_rsp_rdata_i), .slv_rsp_err_i(slv_rsp_err_i),
    .gnt_id_o(gnt_id_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    req_valid_i = 3'b000; req_we_i = 3'b000; rsp_ready_i = 3'b111;
    req_addr_i = 96'h0; req_wdata_i = 96'h0;
    slv_ready_i = 1'b1; slv_rsp_valid_i = 1'b0; slv_rsp_rdata_i = 32'h0; slv_rsp_err_i = 1'b0;

    // Reset state
    step(); step(); #1;
    chk("rst_req_ready", req_ready_o, 64'h0);
    chk("rst_rsp_valid", rsp_valid_o, 64'h0);
    chk("rst_slv_valid", slv_valid_o, 64'h0);
    chk("rst_busy", busy_o, 64'h0);
    chk("rst_gnt", gnt_id_o, 64'h0);
    chk("rst_rdata", rsp_rdata_o, 64'h0);
    chk("rst_err", rsp_err_o, 64'h0);
    rst_n = 1'b1;
    step();

    // Requester 1 reads 0x1A10_0004, zero-wait slave
    slv_rsp_valid_i = 1'b1; slv_rsp_rdata_i = 32'hCAFE_0001;
    req_addr_i[32 +: 32] = 32'h1A10_0004; req_valid_i = 3'b010; #1;
    chk("t1_accept", req_ready_o, 64'h2);
    step(); req_valid_i = 3'b000; #1;
    chk("t1_ready_drop", req_ready_o, 64'h0);
    chk("t1_slv_valid", slv_valid_o, 64'h1);
    chk("t1_slv_addr", slv_addr_o, 64'h1A10_0004);
    chk("t1_slv_we", slv_we_o, 64'h0);
    chk("t1_gnt", gnt_id_o, 64'h1);
    chk("t1_busy", busy_o, 64'h1);
    step(); #1;
    chk("t1_wait_slv_valid", slv_valid_o, 64'h0);
    chk("t1_wait_rsp_ready", slv_rsp_ready_o, 64'h1);
    chk("t1_wait_rsp_valid", rsp_valid_o, 64'h0);
    step(); #1;
    chk("t1_rsp_valid", rsp_valid_o, 64'h2);
    chk("t1_rdata", rsp_rdata_o, 64'hCAFE_0001);
    chk("t1_err", rsp_err_o, 64'h0);
    step(); #1;
    chk("t1_idle_busy", busy_o, 64'h0);
    chk("t1_idle_rsp_valid", rsp_valid_o, 64'h0);

    // Requester 2 writes out of window: decode error
    req_addr_i[64 +: 32] = 32'h0000_1000; req_we_i = 3'b100;
    req_wdata_i[64 +: 32] = 32'h1234_5678; req_valid_i = 3'b100; #1;
    chk("t3_accept", req_ready_o, 64'h4);
    step(); req_valid_i = 3'b000; req_we_i = 3'b000; #1;
    chk("t3_no_slv", slv_valid_o, 64'h0);
    chk("t3_busy", busy_o, 64'h1);
    chk("t3_gnt", gnt_id_o, 64'h2);
    step(); #1;
    chk("t3_rsp_valid", rsp_valid_o, 64'h4);
    chk("t3_err", rsp_err_o, 64'h1);
    chk("t3_rdata", rsp_rdata_o, 64'h0);
    chk("t3_no_slv2", slv_valid_o, 64'h0);
    step();

    // All three valid continuously: order 0,1,2,0,1,2
    for (int j = 0; j < 3; j++) req_addr_i[j*32 +: 32] = 32'h1A10_0000 + 32'(j * 256);
    req_valid_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % 3;
      slv_rsp_rdata_i = 32'h0000_1000 + 32'(e); #1;
      chk("rr_accept", req_ready_o, 64'h1 << e);
      step(); #1;
      chk("rr_gnt", gnt_id_o, 64'(e));
      chk("rr_slv_addr", slv_addr_o, 64'h1A10_0000 + 64'(e * 256));
      chk("rr_no_ready", req_ready_o, 64'h0);
      step(); step(); #1;
      chk("rr_rsp_valid", rsp_valid_o, 64'h1 << e);
      chk("rr_rdata", rsp_rdata_o, 64'h1000 + 64'(e));
      step();
    end
    req_valid_i = 3'b000;

    // Requester 0 writes END_ADDR with slave and response stalls
    req_addr_i[0 +: 32] = 32'h1A11_FFFF; req_we_i = 3'b001; req_wdata_i[0 +: 32] = 32'hDEAD_BEEF;
    slv_ready_i = 1'b0; slv_rsp_valid_i = 1'b0; req_valid_i = 3'b001; #1;
    chk("t4_accept", req_ready_o, 64'h1);
    step();
    req_valid_i = 3'b110; req_we_i = 3'b000;
    req_addr_i[32 +: 32] = 32'h1A10_0000; req_addr_i[64 +: 32] = 32'h1A12_0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_slv_valid", slv_valid_o, 64'h1);
      chk("t4_slv_addr", slv_addr_o, 64'h1A11_FFFF);
      chk("t4_slv_we", slv_we_o, 64'h1);
      chk("t4_slv_wdata", slv_wdata_o, 64'hDEAD_BEEF);
      chk("t4_no_ready", req_ready_o, 64'h0);
      chk("t4_busy", busy_o, 64'h1);
      step();
    end
    slv_ready_i = 1'b1; #1;
    chk("t4_hs_slv_valid", slv_valid_o, 64'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_wait_rsp_ready", slv_rsp_ready_o, 64'h1);
      chk("t4_wait_slv_valid", slv_valid_o, 64'h0);
      chk("t4_wait_rsp_valid", rsp_valid_o, 64'h0);
      chk("t4_wait_no_ready", req_ready_o, 64'h0);
      chk("t4_wait_busy", busy_o, 64'h1);
      step();
    end
    slv_rsp_valid_i = 1'b1; slv_rsp_rdata_i = 32'h5555_AAAA; rsp_ready_i = 3'b110;
    step();
    slv_rsp_valid_i = 1'b0; slv_rsp_rdata_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_rsp_valid", rsp_valid_o, 64'h1);
      chk("t4_rdata", rsp_rdata_o, 64'h5555_AAAA);
      chk("t4_err", rsp_err_o, 64'h0);
      chk("t4_rsp_no_ready", req_ready_o, 64'h0);
      chk("t4_rsp_busy", busy_o, 64'h1);
      step();
    end
    rsp_ready_i = 3'b111; #1;
    chk("t4_rsp_hold", rsp_valid_o, 64'h1);
    step();

    // Slave error on a legal read by requester 1, then requester 2 just above END_ADDR
    slv_rsp_valid_i = 1'b1; slv_rsp_err_i = 1'b1; slv_rsp_rdata_i = 32'h0BAD_0BAD; #1;
    chk("t5_accept", req_ready_o, 64'h2);
    step(); req_valid_i = 3'b100; #1;
    chk("t5_gnt", gnt_id_o, 64'h1);
    chk("t5_slv_addr", slv_addr_o, 64'h1A10_0000);
    step(); step(); #1;
    chk("t5_rsp_valid", rsp_valid_o, 64'h2);
    chk("t5_err", rsp_err_o, 64'h1);
    chk("t5_rdata", rsp_rdata_o, 64'h0BAD_0BAD);
    step(); slv_rsp_err_i = 1'b0; #1;
    chk("t5_next_accept", req_ready_o, 64'h4);
    step(); req_valid_i = 3'b000; #1;
    chk("t5_dec_no_slv", slv_valid_o, 64'h0);
    chk("t5_dec_busy", busy_o, 64'h1);
    step(); #1;
    chk("t5_dec_rsp_valid", rsp_valid_o, 64'h4);
    chk("t5_dec_err", rsp_err_o, 64'h1);
    chk("t5_dec_rdata", rsp_rdata_o, 64'h0);
    step();

    // Complete one requester-1 read, then reset during a second one in WAIT_RSP
    slv_rsp_rdata_i = 32'h7777_0001; req_valid_i = 3'b010; #1;
    chk("t6_accept", req_ready_o, 64'h2);
    step(); req_valid_i = 3'b000;
    step(); step(); #1;
    chk("t6_rsp_valid", rsp_valid_o, 64'h2);
    step();
    slv_rsp_valid_i = 1'b0; req_valid_i = 3'b010; #1;
    chk("t6_accept2", req_ready_o, 64'h2);
    step(); req_valid_i = 3'b000;
    step(); #1;
    chk("t6_in_wait", slv_rsp_ready_o, 64'h1);
    req_addr_i[0 +: 32] = 32'h1A10_0010; req_valid_i = 3'b101;
    rst_n = 1'b0; #1;
    chk("t6_rst_req_ready", req_ready_o, 64'h0);
    chk("t6_rst_rsp_valid", rsp_valid_o, 64'h0);
    chk("t6_rst_rdata", rsp_rdata_o, 64'h0);
    chk("t6_rst_err", rsp_err_o, 64'h0);
    chk("t6_rst_slv_valid", slv_valid_o, 64'h0);
    chk("t6_rst_slv_rsp_ready", slv_rsp_ready_o, 64'h0);
    chk("t6_rst_slv_addr", slv_addr_o, 64'h0);
    chk("t6_rst_gnt", gnt_id_o, 64'h0);
    chk("t6_rst_busy", busy_o, 64'h0);
    step(); rst_n = 1'b1; #1;
    chk("t6_prio0", req_ready_o, 64'h1);
    step(); #1;
    chk("t6_gnt0", gnt_id_o, 64'h0);
    chk("t6_busy", busy_o, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_port_arbiter.md
Name: axi_slave_port_arbiter

Overview:
- Shares one peripheral-side bus slave port between NB_REQ requesters, e.g. the core data master, the debug master and the SPI-slave master.
- Uses round-robin arbitration with one transaction in flight at a time.
- Decodes each request address against a single legal window. Out-of-window requests get an error response without touching the slave.
- Sits between the master-side request ports and a single peripheral slave inside the SoC top level.

Parameters:
- NB_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, read/write data width.
- START_ADDR, 32'h1A10_0000, lowest legal address (inclusive).
- END_ADDR, 32'h1A11_FFFF, highest legal address (inclusive).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NB_REQ  per-requester request valid.
- req_ready_o  out  NB_REQ  per-requester request accept.
- req_addr_i  in  NB_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_we_i  in  NB_REQ  1 = write.
- req_wdata_i  in  NB_REQ*DATA_WIDTH  packed write data.
- rsp_valid_o  out  NB_REQ  per-requester response valid.
- rsp_ready_i  in  NB_REQ  per-requester response accept.
- rsp_rdata_o  out  DATA_WIDTH  shared response data.
- rsp_err_o  out  1  shared response error flag.
- slv_valid_o  out  1  slave request valid.
- slv_ready_i  in  1  slave request accept.
- slv_addr_o  out  ADDR_WIDTH  slave address.
- slv_we_o  out  1  slave write enable.
- slv_wdata_o  out  DATA_WIDTH  slave write data.
- slv_rsp_valid_i  in  1  slave response valid.
- slv_rsp_ready_o  out  1  slave response accept.
- slv_rsp_rdata_i  in  DATA_WIDTH  slave read data.
- slv_rsp_err_i  in  1  slave error.
- gnt_id_o  out  $clog2(NB_REQ)  index of the current or last granted requester.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; round-robin pointer = NB_REQ-1, so requester 0 has top priority first; FSM = IDLE.
- States: IDLE, ISSUE, WAIT_RSP, DEC_ERR, RESP.
- IDLE, arbitration:
  - If any req_valid_i is high, pick the first valid index scanning from (ptr+1) mod NB_REQ upward with wrap.
  - Combinationally assert req_ready_o[winner] in that cycle, the only accept cycle.
  - Register addr/we/wdata and winner into gnt_id_o.
  - Go to ISSUE if START_ADDR <= addr <= END_ADDR (unsigned, full width), else DEC_ERR.
  - req_ready_o is never high outside IDLE and never for more than one index.
- ISSUE:
  - slv_valid_o=1 with the latched fields held stable until slv_ready_i.
  - On handshake go to WAIT_RSP. No abort.
- WAIT_RSP:
  - slv_rsp_ready_o=1.
  - On slv_rsp_valid_i, latch rdata and err (read data latched for writes too), then go to RESP.
  - A response in the same cycle as the ISSUE handshake is not possible: slv_rsp_ready_o is 0 in ISSUE.
- DEC_ERR: one cycle. Set rdata=0, err=1, go to RESP.
- RESP:
  - rsp_valid_o[gnt_id_o]=1, with rsp_rdata_o and rsp_err_o stable, until rsp_ready_i[gnt_id_o].
  - Then ptr <= gnt_id_o and go to IDLE.
  - rsp_rdata_o and rsp_err_o hold their last value in other states.
- Latency: minimum accept-to-response-valid is 3 cycles with slave zero-wait (IDLE→ISSUE→WAIT_RSP→RESP); a decode error takes 2 cycles.
- Back-to-back: the next grant occurs earliest in the cycle after the RESP handshake.
- Fairness:
  - A requester holding valid is granted within NB_REQ transactions.
  - A winner keeping valid high is re-granted only after all other valid requesters have been served.
- Requesters must hold valid/fields until ready. Dropping valid before grant is permitted and simply removes the request.
- slv_rsp_valid_i outside WAIT_RSP is ignored (slv_rsp_ready_o=0).
- Asynchronous reset mid-transaction: FSM returns to IDLE, all outputs drop to 0, and the pending transaction is lost. Slave reset is common, so no orphan handling.

Test Plan:
- Reset, then requester 1 reads 0x1A10_0004; slave returns 0xCAFE_0001 zero-wait → req_ready_o=3'b010 for 1 cycle; slv_addr_o=0x1A10_0004; rsp_valid_o=3'b010 in the 3rd cycle after accept; rdata 0xCAFE_0001; err=0.
- All three valid continuously, each to a legal address → grant order 0,1,2,0,1,2; gnt_id_o matches; no index served twice while another waits.
- Requester 2 writes 0x0000_1000 (out of window) → no slv_valid_o pulse; rsp_valid_o[2] 2 cycles after accept; err=1; rdata=0.
- Slave holds slv_ready_i low 5 cycles and slv_rsp_valid_i low 4 more; requester 0 holds rsp_ready_i low 3 cycles → slave fields stable throughout; rsp data stable while stalled; req_ready_o stays 0 for the other requesters; busy_o=1 for the whole transaction.
- Slave returns slv_rsp_err_i=1 on a legal read → rsp_err_o=1 to the granted requester; next grant proceeds normally.
- rst_n asserted while in WAIT_RSP → all outputs 0 immediately (asynchronous); after release, requester 0 has priority over simultaneous valid on requesters 0 and 2.
